// File: rtl/irq_cause_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_cause_receiver_if
// Brief    : Interrupt-cause request and dequeue signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_cause_receiver_if #(
  parameter int CNT_W = 3
);
  logic             io_irq;
  logic [5:0]       io_irq_cause;
  logic             io_deq_ready;
  logic             io_deq_valid;
  logic             io_deq_bits_intr;
  logic [4:0]       io_deq_bits_code;
  logic [CNT_W-1:0] io_pending;
  logic             io_overflow;
  logic             io_clear_overflow;

  modport master (
    output io_irq, io_irq_cause, io_deq_ready, io_clear_overflow,
    input  io_deq_valid, io_deq_bits_intr, io_deq_bits_code, io_pending, io_overflow
  );

  modport slave (
    input  io_irq, io_irq_cause, io_deq_ready, io_clear_overflow,
    output io_deq_valid, io_deq_bits_intr, io_deq_bits_code, io_pending, io_overflow
  );
endinterface
`default_nettype wire

// File: rtl/irq_cause_receiver.sv
`default_nettype none
// ============================================================================
// Module   : irq_cause_receiver
// Brief    : Captures one cause word per io_irq rising edge into a FIFO and
//            presents entries on a valid/ready dequeue port.
// Revision : 1.0 - initial release
// ============================================================================
module irq_cause_receiver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  irq_cause_receiver_if.slave bus
);
  localparam int             c_PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

  logic               r_irq_prev;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [5:0]         r_mem [DEPTH];

  logic w_capture;
  logic w_empty;
  logic w_full;
  logic w_deq_fire;
  logic w_enq;
  logic w_drop;
  logic [5:0] w_head_word;

  assign w_capture  = bus.io_irq & ~r_irq_prev;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL_CNT);
  assign w_deq_fire = ~w_empty & bus.io_deq_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_enq      = w_capture & (~w_full | w_deq_fire);
  assign w_drop     = w_capture & w_full & ~w_deq_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_irq_prev <= bus.io_irq;
      if (w_enq) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_enq, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.io_clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= bus.io_irq_cause;
    end
  end

  assign w_head_word          = w_empty ? 6'd0 : r_mem[r_head];
  assign bus.io_deq_valid     = ~w_empty;
  assign bus.io_deq_bits_intr = w_head_word[5];
  assign bus.io_deq_bits_code = w_head_word[4:0];
  assign bus.io_pending       = r_count;
  assign bus.io_overflow      = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_irq_cause_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_cause_receiver
// Brief    : Scoreboard bench for irq_cause_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_cause_receiver;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [5:0] sb [$];
  bit         m_prev = 1'b0;
  bit         m_ovf  = 1'b0;

  irq_cause_receiver_if #(.CNT_W(CNT_W)) bus ();

  irq_cause_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit cap, fire, drop;
    if (reset) begin
      sb.delete();
      m_prev = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      chk("valid", 32'(bus.io_deq_valid), 32'(sb.size() != 0));
      chk("pending", 32'(bus.io_pending), 32'(sb.size()));
      chk("overflow", 32'(bus.io_overflow), 32'(m_ovf));
      if (sb.size() == 0)
        chk("idle_bits", 32'({bus.io_deq_bits_intr, bus.io_deq_bits_code}), 32'd0);
      cap  = bus.io_irq & ~m_prev;
      fire = bus.io_deq_ready && (sb.size() != 0);
      drop = 1'b0;
      if (fire) begin
        chk("deq_word", 32'({bus.io_deq_bits_intr, bus.io_deq_bits_code}), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (cap) begin
        if (sb.size() < DEPTH) sb.push_back(bus.io_irq_cause);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (bus.io_clear_overflow) m_ovf = 1'b0;
      m_prev = bus.io_irq;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] cause);
    bus.io_irq       = 1'b1;
    bus.io_irq_cause = cause;
    tick();
    bus.io_irq       = 1'b0;
    bus.io_irq_cause = ~cause;
    tick();
  endtask

  task automatic drain();
    int i;
    bus.io_deq_ready = 1'b1;
    i = 0;
    while (sb.size() != 0 && i < 20) begin
      tick();
      i++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    bus.io_deq_ready = 1'b0;
    tick();
    chk("drain_empty", 32'(bus.io_deq_valid), 32'd0);
  endtask

  initial begin
    bus.io_irq            = 1'b0;
    bus.io_irq_cause      = 6'h00;
    bus.io_deq_ready      = 1'b0;
    bus.io_clear_overflow = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.io_deq_valid), 32'd0);
    chk("rst_pending", 32'(bus.io_pending), 32'd0);
    chk("rst_overflow", 32'(bus.io_overflow), 32'd0);
    chk("rst_bits", 32'({bus.io_deq_bits_intr, bus.io_deq_bits_code}), 32'd0);
    repeat (3) tick();
    reset = 1'b0;

    // Single capture with one-cycle latency
    repeat (4) tick();
    bus.io_irq       = 1'b1;
    bus.io_irq_cause = 6'h22;
    tick();
    bus.io_irq       = 1'b0;
    bus.io_irq_cause = 6'h3D;
    chk("t1_valid", 32'(bus.io_deq_valid), 32'd1);
    chk("t1_intr", 32'(bus.io_deq_bits_intr), 32'd1);
    chk("t1_code", 32'(bus.io_deq_bits_code), 32'h02);
    chk("t1_pending", 32'(bus.io_pending), 32'd1);
    bus.io_deq_ready = 1'b1;
    tick();
    bus.io_deq_ready = 1'b0;
    chk("t1_valid_after", 32'(bus.io_deq_valid), 32'd0);
    chk("t1_pending_after", 32'(bus.io_pending), 32'd0);

    // Held level captures once
    bus.io_irq       = 1'b1;
    bus.io_irq_cause = 6'h22;
    repeat (10) tick();
    bus.io_irq = 1'b0;
    tick();
    chk("t2_pending", 32'(bus.io_pending), 32'd1);
    drain();

    // Ordering across pointer wrap
    pulse(6'h21); pulse(6'h22); pulse(6'h23);
    bus.io_deq_ready = 1'b1;
    repeat (2) tick();
    bus.io_deq_ready = 1'b0;
    pulse(6'h24); pulse(6'h25);
    chk("t3_pending", 32'(bus.io_pending), 32'd3);
    drain();

    // Overflow, clear, and set-beats-clear
    for (int k = 1; k <= 5; k++) pulse(6'(k));
    chk("t4_pending", 32'(bus.io_pending), 32'd4);
    chk("t4_overflow", 32'(bus.io_overflow), 32'd1);
    bus.io_clear_overflow = 1'b1;
    tick();
    bus.io_clear_overflow = 1'b0;
    chk("t4_cleared", 32'(bus.io_overflow), 32'd0);
    bus.io_irq            = 1'b1;
    bus.io_irq_cause      = 6'h06;
    bus.io_clear_overflow = 1'b1;
    tick();
    bus.io_irq            = 1'b0;
    bus.io_clear_overflow = 1'b0;
    chk("t4_set_wins", 32'(bus.io_overflow), 32'd1);
    bus.io_clear_overflow = 1'b1;
    tick();
    bus.io_clear_overflow = 1'b0;
    drain();

    // Full FIFO with simultaneous dequeue accepts the new entry
    for (int k = 0; k < 4; k++) pulse(6'h10 + 6'(k));
    bus.io_irq       = 1'b1;
    bus.io_irq_cause = 6'h3F;
    bus.io_deq_ready = 1'b1;
    tick();
    bus.io_irq       = 1'b0;
    bus.io_deq_ready = 1'b0;
    chk("t5_pending", 32'(bus.io_pending), 32'd4);
    chk("t5_overflow", 32'(bus.io_overflow), 32'd0);
    drain();

    // Async reset mid-cycle, irq held high across release
    pulse(6'h2A); pulse(6'h2B); pulse(6'h2C);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.io_deq_valid), 32'd0);
    chk("t6_pending", 32'(bus.io_pending), 32'd0);
    bus.io_irq       = 1'b1;
    bus.io_irq_cause = 6'h31;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("t6_one_capture", 32'(bus.io_pending), 32'd1);
    repeat (4) tick();
    chk("t6_still_one", 32'(bus.io_pending), 32'd1);
    bus.io_irq = 1'b0;
    drain();

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
